// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller: latches a mult/div result at issue, holds it
// for a fixed busy window, then commits it to HI/LO with a one-cycle done pulse.
module mdu_ctrl #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       MDUOp,
  input  logic             start,
  input  logic             cancel,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             busy,
  output logic             done
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [CW-1:0]    MULT_LOAD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0]    DIV_LOAD  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0]    CNT_ONE   = CW'(1);
  localparam logic [CW-1:0]    CNT_ZERO  = {CW{1'b0}};
  localparam logic [WIDTH-1:0] W_ZERO    = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] W_ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  state_t             state_r;
  logic [CW-1:0]      cnt_r;
  logic [WIDTH-1:0]   res_hi_r;
  logic [WIDTH-1:0]   res_lo_r;
  logic               res_wr_r;

  logic               signed_op_s;
  logic [2*WIDTH-1:0] ext_a_s;
  logic [2*WIDTH-1:0] ext_b_s;
  logic [2*WIDTH-1:0] prod_s;
  logic               a_neg_s;
  logic               b_neg_s;
  logic               div_zero_s;
  logic [WIDTH-1:0]   a_mag_s;
  logic [WIDTH-1:0]   b_mag_s;
  logic [WIDTH-1:0]   den_s;
  logic [WIDTH-1:0]   q_mag_s;
  logic [WIDTH-1:0]   r_mag_s;
  logic [WIDTH-1:0]   quot_s;
  logic [WIDTH-1:0]   rem_s;
  logic [WIDTH-1:0]   res_hi_s;
  logic [WIDTH-1:0]   res_lo_s;
  logic               res_wr_s;
  logic               op_run_s;
  logic [CW-1:0]      load_s;

  // Arithmetic datapath: sign-extended product and sign-magnitude division.
  // Magnitude division makes min/-1 wrap to min with a zero remainder.
  always_comb begin
    signed_op_s = (MDUOp == OP_MULT) || (MDUOp == OP_DIV);
    a_neg_s     = signed_op_s & A[WIDTH-1];
    b_neg_s     = signed_op_s & B[WIDTH-1];
    ext_a_s     = {{WIDTH{a_neg_s}}, A};
    ext_b_s     = {{WIDTH{b_neg_s}}, B};
    prod_s      = ext_a_s * ext_b_s;
    a_mag_s     = a_neg_s ? -A : A;
    b_mag_s     = b_neg_s ? -B : B;
    div_zero_s  = (B == W_ZERO);
    den_s       = div_zero_s ? W_ONE : b_mag_s;
    q_mag_s     = a_mag_s / den_s;
    r_mag_s     = a_mag_s % den_s;
    quot_s      = (a_neg_s ^ b_neg_s) ? -q_mag_s : q_mag_s;
    rem_s       = a_neg_s ? -r_mag_s : r_mag_s;
  end

  // Opcode decode: result to latch, whether to commit it, and busy length.
  always_comb begin
    res_hi_s = W_ZERO;
    res_lo_s = W_ZERO;
    res_wr_s = 1'b0;
    op_run_s = 1'b0;
    load_s   = CNT_ZERO;
    case (MDUOp)
      OP_MULT, OP_MULTU: begin
        res_hi_s = prod_s[2*WIDTH-1:WIDTH];
        res_lo_s = prod_s[WIDTH-1:0];
        res_wr_s = 1'b1;
        op_run_s = 1'b1;
        load_s   = MULT_LOAD;
      end
      OP_DIV, OP_DIVU: begin
        res_hi_s = rem_s;
        res_lo_s = quot_s;
        res_wr_s = !div_zero_s;
        op_run_s = 1'b1;
        load_s   = DIV_LOAD;
      end
      default: begin
        op_run_s = 1'b0;
      end
    endcase
  end

  // Control FSM with registered HI/LO/busy/done.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= IDLE;
      cnt_r    <= CNT_ZERO;
      res_hi_r <= W_ZERO;
      res_lo_r <= W_ZERO;
      res_wr_r <= 1'b0;
      HI       <= W_ZERO;
      LO       <= W_ZERO;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start && !cancel) begin
            if (op_run_s) begin
              res_hi_r <= res_hi_s;
              res_lo_r <= res_lo_s;
              res_wr_r <= res_wr_s;
              cnt_r    <= load_s;
              busy     <= 1'b1;
              state_r  <= RUN;
            end else if (MDUOp == OP_MTHI) begin
              HI <= A;
            end else if (MDUOp == OP_MTLO) begin
              LO <= A;
            end
          end
        end
        RUN: begin
          if (cancel) begin
            cnt_r   <= CNT_ZERO;
            busy    <= 1'b0;
            done    <= 1'b0;
            state_r <= IDLE;
          end else if (cnt_r == CNT_ONE) begin
            if (res_wr_r) begin
              HI <= res_hi_r;
              LO <= res_lo_r;
            end
            cnt_r   <= CNT_ZERO;
            busy    <= 1'b0;
            done    <= 1'b1;
            state_r <= IDLE;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
            done  <= 1'b0;
          end
        end
        default: begin
          cnt_r   <= CNT_ZERO;
          busy    <= 1'b0;
          done    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: inputs driven and outputs sampled on the
// falling edge, expected values hand-computed.
module tb_mdu_ctrl;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  MDUOp;
  logic        start;
  logic        cancel;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;

  mdu_ctrl #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .MDUOp(MDUOp), .start(start), .cancel(cancel),
    .A(A), .B(B), .HI(HI), .LO(LO), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    MDUOp = op;
    A     = a;
    B     = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    MDUOp = OP_NONE;
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int n,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    issue(op, a, b);
    for (int i = 1; i <= n; i++) begin
      chk($sformatf("%s busy c%0d", tag, i), 32'(busy), 32'd1);
      chk($sformatf("%s nodone c%0d", tag, i), 32'(done), 32'd0);
      @(negedge clk);
    end
    chk({tag, " busy_end"}, 32'(busy), 32'd0);
    chk({tag, " done"}, 32'(done), 32'd1);
    chk({tag, " HI"}, HI, exp_hi);
    chk({tag, " LO"}, LO, exp_lo);
    @(negedge clk);
    chk({tag, " done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    reset  = 1'b0;
    MDUOp  = OP_NONE;
    start  = 1'b0;
    cancel = 1'b0;
    A      = 32'd0;
    B      = 32'd0;
    #12;
    chk("rst HI", HI, 32'd0);
    chk("rst LO", LO, 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    run_op("mult", OP_MULT, 32'hFFFFFFFF, 32'd2, 5, 32'hFFFFFFFF, 32'hFFFFFFFE);
    run_op("multu", OP_MULTU, 32'hFFFFFFFF, 32'd2, 5, 32'h00000001, 32'hFFFFFFFE);
    run_op("div -7/2", OP_DIV, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div min/-1", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000);
    run_op("div 7/-2", OP_DIV, 32'd7, 32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD);
    run_op("divu 100/7", OP_DIVU, 32'd100, 32'd7, 10, 32'd2, 32'd14);

    issue(OP_MTHI, 32'h1234, 32'd0);
    chk("mthi HI", HI, 32'h1234);
    chk("mthi busy", 32'(busy), 32'd0);
    chk("mthi done", 32'(done), 32'd0);
    issue(OP_MTLO, 32'h1234, 32'd0);
    chk("mtlo LO", LO, 32'h1234);
    chk("mtlo busy", 32'(busy), 32'd0);
    run_op("divu by0", OP_DIVU, 32'd7, 32'd0, 10, 32'h1234, 32'h1234);

    // mthi and mult started mid-multu must be dropped
    issue(OP_MULTU, 32'd3, 32'd4);
    @(negedge clk);
    MDUOp = OP_MTHI; A = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ign mthi HI", HI, 32'h1234);
    @(negedge clk);
    MDUOp = OP_MULT; A = 32'd7; B = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0; MDUOp = OP_NONE;
    chk("ign busy c5", 32'(busy), 32'd1);
    @(negedge clk);
    chk("ign done", 32'(done), 32'd1);
    chk("ign HI", HI, 32'd0);
    chk("ign LO", LO, 32'd12);
    @(negedge clk);
    chk("ign no_restart", 32'(busy), 32'd0);

    // start held across the final count is taken on the first IDLE cycle
    issue(OP_MULT, 32'd2, 32'd3);
    for (int i = 1; i <= 4; i++) @(negedge clk);
    MDUOp = OP_MTLO; A = 32'h77; start = 1'b1;
    @(negedge clk);
    chk("last LO", LO, 32'd6);
    chk("last done", 32'(done), 32'd1);
    @(negedge clk);
    start = 1'b0; MDUOp = OP_NONE;
    chk("last mtlo LO", LO, 32'h77);
    chk("last busy", 32'(busy), 32'd0);

    cancel = 1'b1; start = 1'b1; MDUOp = OP_MTHI; A = 32'hAB;
    @(negedge clk);
    cancel = 1'b0; start = 1'b0; MDUOp = OP_NONE;
    chk("cancel prio HI", HI, 32'd0);

    issue(OP_DIV, 32'd100, 32'd3);
    @(negedge clk);
    @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("cancel busy", 32'(busy), 32'd0);
    chk("cancel done", 32'(done), 32'd0);
    chk("cancel HI", HI, 32'd0);
    chk("cancel LO", LO, 32'h77);
    run_op("mult after cancel", OP_MULT, 32'hFFFFFFFD, 32'd4, 5, 32'hFFFFFFFF, 32'hFFFFFFF4);

    // asynchronous reset in the middle of a divide
    issue(OP_DIV, 32'd50, 32'd7);
    for (int i = 1; i <= 5; i++) @(negedge clk);
    chk("pre-rst busy", 32'(busy), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst HI", HI, 32'd0);
    chk("arst LO", LO, 32'd0);
    chk("arst busy", 32'(busy), 32'd0);
    chk("arst done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    issue(OP_MTLO, 32'd9, 32'd0);
    chk("post-rst LO", LO, 32'd9);
    chk("post-rst HI", HI, 32'd0);
    chk("post-rst busy", 32'(busy), 32'd0);
    for (int i = 1; i <= 12; i++) begin
      chk($sformatf("post-rst nodone c%0d", i), 32'(done), 32'd0);
      @(negedge clk);
    end
    chk("post-rst LO hold", LO, 32'd9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
